queue_ctrl_2x105: RTL and testbench

QUEUE_CTRL_2X105 -- requirements
Module: queue_ctrl_2x105

---
 rtl/queue_ctrl_2x105_if.sv | 23 ++
 rtl/queue_ctrl_2x105.sv | 97 +++++++++
 tb/tb_queue_ctrl_2x105.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/queue_ctrl_2x105_if.sv
// Handshake bundle for queue_ctrl_2x105.
//   enq_valid/enq_ready/enq_bits : producer side, 105-bit payload in
//   deq_valid/deq_ready/deq_bits : consumer side, 105-bit payload out
// master : the agent driving the queue (producer + consumer)
// slave  : the queue controller itself
interface queue_ctrl_2x105_if;
    logic         enq_valid;
    logic         enq_ready;
    logic [104:0] enq_bits;
    logic         deq_valid;
    logic         deq_ready;
    logic [104:0] deq_bits;

    modport master (
        output enq_valid, enq_bits, deq_ready,
        input  enq_ready, deq_valid, deq_bits
    );

    modport slave (
        input  enq_valid, enq_bits, deq_ready,
        output enq_ready, deq_valid, deq_bits
    );
endinterface

// File: rtl/queue_ctrl_2x105.sv
// Two-entry queue controller driving an external 2x105 storage macro.
//
// Ports:
//   clock        : single clock, rising edge
//   reset        : synchronous active-low reset
//   io           : enq/deq valid-ready handshakes (slave side)
//   count        : entries held in storage (0..2)
//   mem_W0_*     : storage write port (addr, en, data); W0_clk tied to clock
//   mem_R0_*     : storage read port (addr, en out; data in, combinational)
//
// Parameters:
//   FLOW : enq data may bypass empty storage straight to deq
//   PIPE : enq_ready also asserted when full if deq_ready is high
module queue_ctrl_2x105 #(
    parameter bit FLOW = 1'b0,
    parameter bit PIPE = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    queue_ctrl_2x105_if.slave    io,
    output logic [1:0]           count,
    output logic                 mem_W0_addr,
    output logic                 mem_W0_en,
    output logic [104:0]         mem_W0_data,
    output logic                 mem_R0_addr,
    output logic                 mem_R0_en,
    input  logic [104:0]         mem_R0_data
);

    logic enq_ptr_r;
    logic deq_ptr_r;
    logic maybe_full_r;

    logic ptr_match_s;
    logic empty_s;
    logic full_s;
    logic bypass_s;
    logic do_enq_s;
    logic do_deq_s;
    logic wr_s;
    logic rd_s;

    assign ptr_match_s = (enq_ptr_r == deq_ptr_r);
    assign empty_s     = ptr_match_s & ~maybe_full_r;
    assign full_s      = ptr_match_s & maybe_full_r;

    // Bypass path is only meaningful when FLOW is enabled and storage is empty.
    assign bypass_s    = FLOW & empty_s;

    assign io.enq_ready = ~full_s | (PIPE & io.deq_ready);
    assign io.deq_valid = ~empty_s | (FLOW & io.enq_valid);
    assign io.deq_bits  = bypass_s ? io.enq_bits : mem_R0_data;

    assign do_enq_s = io.enq_valid & io.enq_ready;
    assign do_deq_s = io.deq_valid & io.deq_ready;

    // Effective storage write: a bypassed item never touches storage, and
    // handshakes in a reset cycle are discarded so storage stays untouched.
    assign wr_s = do_enq_s & ~(bypass_s & io.deq_ready) & reset;
    // Effective storage read: a dequeue served from the bypass does not pop.
    assign rd_s = do_deq_s & ~bypass_s;

    assign mem_W0_addr = enq_ptr_r;
    assign mem_W0_en   = wr_s;
    assign mem_W0_data = io.enq_bits;
    assign mem_R0_addr = deq_ptr_r;
    assign mem_R0_en   = 1'b1;

    assign count = {full_s, enq_ptr_r ^ deq_ptr_r};

    // Pointer and fullness state; reset wins over any concurrent handshake.
    always_ff @(posedge clock) begin
        if (!reset) begin
            enq_ptr_r    <= 1'b0;
            deq_ptr_r    <= 1'b0;
            maybe_full_r <= 1'b0;
        end else begin
            if (wr_s) begin
                enq_ptr_r <= ~enq_ptr_r;
            end else begin
                enq_ptr_r <= enq_ptr_r;
            end
            if (rd_s) begin
                deq_ptr_r <= ~deq_ptr_r;
            end else begin
                deq_ptr_r <= deq_ptr_r;
            end
            // Equal pointers are disambiguated by the last unbalanced operation.
            if (wr_s != rd_s) begin
                maybe_full_r <= wr_s;
            end else begin
                maybe_full_r <= maybe_full_r;
            end
        end
    end

endmodule

// File: tb/tb_queue_ctrl_2x105.sv
// Self-checking bench for queue_ctrl_2x105. All four FLOW/PIPE variants run
// side by side on the same stimulus, each against an ordered-list model.
module tb_queue_ctrl_2x105;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         enq_valid = 1'b0;
    logic [104:0] enq_bits  = 105'd0;
    logic         deq_ready = 1'b0;

    logic [3:0]   obs_enq_ready;
    logic [3:0]   obs_deq_valid;
    logic [104:0] obs_deq_bits [4];
    logic [1:0]   obs_count    [4];
    logic [3:0]   obs_w_en;
    logic [3:0]   obs_r_en;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: per-variant ordered list of held items, head at index 0.
    logic [104:0] mdl_q   [4][2];
    int           mdl_cnt [4];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        queue_ctrl_2x105_if ifc ();
        logic         w_addr;
        logic         w_en;
        logic [104:0] w_data;
        logic         r_addr;
        logic         r_en;
        logic [104:0] r_data;
        logic [1:0]   cnt;
        logic [104:0] mem [2];

        assign ifc.enq_valid = enq_valid;
        assign ifc.enq_bits  = enq_bits;
        assign ifc.deq_ready = deq_ready;

        queue_ctrl_2x105 #(
            .FLOW((g & 1) != 0),
            .PIPE((g & 2) != 0)
        ) dut (
            .clock       (clock),
            .reset       (reset),
            .io          (ifc),
            .count       (cnt),
            .mem_W0_addr (w_addr),
            .mem_W0_en   (w_en),
            .mem_W0_data (w_data),
            .mem_R0_addr (r_addr),
            .mem_R0_en   (r_en),
            .mem_R0_data (r_data)
        );

        // External 2x105 storage: clocked write, combinational read.
        always @(posedge clock) begin
            if (w_en) mem[w_addr] <= w_data;
        end
        assign r_data = mem[r_addr];

        assign obs_enq_ready[g] = ifc.enq_ready;
        assign obs_deq_valid[g] = ifc.deq_valid;
        assign obs_deq_bits[g]  = ifc.deq_bits;
        assign obs_count[g]     = cnt;
        assign obs_w_en[g]      = w_en;
        assign obs_r_en[g]      = r_en;
    end

    task automatic check_val(input string tag, input logic [104:0] obs, input logic [104:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check combinational
    // outputs of every variant against the model, then advance the model.
    task automatic cycle(input logic ev, input logic [104:0] eb, input logic dr, input logic rs);
        @(negedge clock);
        enq_valid = ev;
        enq_bits  = eb;
        deq_ready = dr;
        reset     = rs;
        #1;
        for (int c = 0; c < 4; c++) begin
            bit flow, pipe, e_er, e_dv, e_we, do_e, do_d;
            flow = (c & 1) != 0;
            pipe = (c & 2) != 0;
            e_er = (mdl_cnt[c] < 2) || (pipe && dr);
            e_dv = (mdl_cnt[c] > 0) || (flow && ev);
            do_e = ev && e_er;
            do_d = e_dv && dr;
            e_we = rs && do_e && !(flow && mdl_cnt[c] == 0 && dr);
            check_val($sformatf("w_en[%0d]", c), 105'(obs_w_en[c]), 105'(e_we));
            if (rs) begin
                check_val($sformatf("enq_ready[%0d]", c), 105'(obs_enq_ready[c]), 105'(e_er));
                check_val($sformatf("deq_valid[%0d]", c), 105'(obs_deq_valid[c]), 105'(e_dv));
                check_val($sformatf("count[%0d]", c), 105'(obs_count[c]), 105'(mdl_cnt[c]));
                check_val($sformatf("r_en[%0d]", c), 105'(obs_r_en[c]), 105'd1);
                if (e_dv)
                    check_val($sformatf("deq_bits[%0d]", c), obs_deq_bits[c],
                              (mdl_cnt[c] > 0) ? mdl_q[c][0] : eb);
            end
            if (!rs) begin
                mdl_cnt[c] = 0;
            end else if (flow && mdl_cnt[c] == 0 && do_e && do_d) begin
                // item passes straight through
            end else begin
                if (do_d) begin
                    mdl_q[c][0] = mdl_q[c][1];
                    mdl_cnt[c]  = mdl_cnt[c] - 1;
                end
                if (do_e) begin
                    mdl_q[c][mdl_cnt[c]] = eb;
                    mdl_cnt[c] = mdl_cnt[c] + 1;
                end
            end
        end
        @(posedge clock);
    endtask

    function automatic logic [104:0] rnd_bits();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[104:0];
    endfunction

    initial begin
        for (int c = 0; c < 4; c++) begin
            mdl_cnt[c]  = 0;
            mdl_q[c][0] = 105'd0;
            mdl_q[c][1] = 105'd0;
        end
        // Reset, then two back-to-back enqueues with the consumer stalled.
        cycle(1'b0, 105'd0, 1'b0, 1'b0);
        cycle(1'b0, 105'd0, 1'b0, 1'b0);
        cycle(1'b1, 105'h1, 1'b0, 1'b1);
        cycle(1'b1, 105'h2, 1'b0, 1'b1);
        cycle(1'b1, 105'h3, 1'b0, 1'b1);   // full: enq_ready low (PIPE off)
        // Drain the full queue.
        cycle(1'b0, 105'd0, 1'b1, 1'b1);
        cycle(1'b0, 105'd0, 1'b1, 1'b1);
        cycle(1'b0, 105'd0, 1'b1, 1'b1);
        // Steady state at one entry with simultaneous enq/deq; pointers wrap.
        cycle(1'b1, 105'h10, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 105'(32'h10 + i), 1'b1, 1'b1);
        cycle(1'b0, 105'd0, 1'b1, 1'b1);
        cycle(1'b0, 105'd0, 1'b1, 1'b1);
        // Empty with simultaneous enq/deq: FLOW bypass case.
        cycle(1'b1, 105'hAB, 1'b1, 1'b1);
        cycle(1'b0, 105'd0, 1'b0, 1'b1);
        // Fill, then enq+deq while full: PIPE case.
        cycle(1'b1, 105'h21, 1'b0, 1'b1);
        cycle(1'b1, 105'h22, 1'b0, 1'b1);
        cycle(1'b1, 105'h23, 1'b1, 1'b1);
        cycle(1'b1, 105'h24, 1'b1, 1'b1);
        // Reset while full with both handshakes offered.
        cycle(1'b1, 105'h25, 1'b0, 1'b1);
        cycle(1'b1, 105'h26, 1'b1, 1'b0);
        cycle(1'b0, 105'd0, 1'b0, 1'b1);
        cycle(1'b1, 105'h27, 1'b0, 1'b1);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic rs;
            rs = ($urandom_range(0, 49) != 0);
            cycle(1'($urandom_range(0, 1)), rnd_bits(), 1'($urandom_range(0, 1)), rs);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
